b128to32_ser: RTL and testbench

Downstream counterpart of the 32-to-128 deserializer on the 32-bit datapath. It accepts one 128-bit block per valid/ready handshake and emits it as four 32-bit words, most significant word first, on a valid/ready output stream. The current block and one waiting block are held in registers, so a block stream runs at one word per cycle with no bubbles.

---
 rtl/b128to32_ser_pkg.sv | 12 +
 rtl/b128to32_ser.sv | 80 ++++++++
 tb/tb_b128to32_ser.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/b128to32_ser_pkg.sv
// Shared constants and types for the 128-to-32 serializer.
// Word width, words per block and the word-index type used by nr.
package b128to32_ser_pkg;

  localparam int WORD_W  = 32;
  localparam int NWORDS  = 4;
  localparam int BLOCK_W = WORD_W * NWORDS;

  // Same numbering as the deserializer's nr output.
  typedef logic [1:0] word_idx_t;

endpackage

// File: rtl/b128to32_ser.sv
// Serializes 128-bit blocks into four 32-bit words, MSW first.
// Ports: clock, reset, inValid/inReady/dataIn (block in),
//        outValid/outReady/dataOut/nr/last (word out).
module b128to32_ser
  import b128to32_ser_pkg::*;
#(
  parameter int W = WORD_W,
  parameter int N = NWORDS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inValid,
  input  logic [W*N-1:0]       dataIn,
  output logic                 inReady,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [W-1:0]         dataOut,
  output logic [$clog2(N)-1:0] nr,
  output logic                 last
);

  localparam int BW = W * N;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic [BW-1:0] cur;
  logic [BW-1:0] hold;
  logic [CW-1:0] cnt;
  logic          hold_valid;

  logic consume;
  logic take;
  logic drain_last;
  logic cur_free;
  logic cur_reload;
  logic load_cur;
  logic load_hold;

  assign outValid = (cnt != '0);
  assign dataOut  = cur[BW-1 -: W];
  assign nr       = IW'(N - int'(cnt));
  assign last     = outValid && (cnt == CW'(1));
  // Registered state plus reset only: no path from outReady.
  assign inReady  = !hold_valid && !reset;

  assign consume    = outValid && outReady;
  assign take       = inValid && inReady;
  assign drain_last = consume && (cnt == CW'(1));
  assign cur_free   = (cnt == '0) || drain_last;
  // take implies !hold_valid, so reload and take never coincide.
  assign cur_reload = drain_last && hold_valid;
  assign load_cur   = take && cur_free;
  assign load_hold  = take && !cur_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur        <= '0;
      hold       <= '0;
      cnt        <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (cur_reload) begin
        cur        <= hold;
        cnt        <= CW'(N);
        hold_valid <= 1'b0;
      end else if (load_cur) begin
        cur <= dataIn;
        cnt <= CW'(N);
      end else if (consume) begin
        cur <= cur << W;
        cnt <= cnt - CW'(1);
      end
      if (load_hold) begin
        hold       <= dataIn;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_b128to32_ser.sv
// Scoreboard bench for b128to32_ser: directed cases then random traffic.
// Accepted blocks expand into expected words popped on each consume.
module tb_b128to32_ser;
  import b128to32_ser_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    word_idx_t   nr;
    logic        last;
  } word_t;

  localparam logic [127:0] K =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D =
    128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic [127:0] dataIn = '0;
  logic         inReady;
  logic         outValid;
  logic [31:0]  dataOut;
  logic [1:0]   nr;
  logic         last;

  int    errors = 0;
  int    checks = 0;
  word_t q[$];

  always #5 clock = ~clock;

  b128to32_ser dut (
    .clock    (clock),
    .reset    (reset),
    .inValid  (inValid),
    .dataIn   (dataIn),
    .inReady  (inReady),
    .outValid (outValid),
    .outReady (outReady),
    .dataOut  (dataOut),
    .nr       (nr),
    .last     (last)
  );

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic idle(int n);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (n) step();
  endtask

  // Reference: outstanding words = words left in the current block
  // plus a full waiting block, so more than 4 means the hold is full.
  always @(negedge clock) begin
    word_t w;
    chk("outValid", outValid, q.size() != 0);
    chk("inReady", inReady, !reset && q.size() <= 4);
    if (!outValid) chk("idle_data", dataOut, 0);
    if (reset) begin
      q.delete();
    end else begin
      if (outValid && outReady) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h want none", dataOut);
        end else begin
          w = q.pop_front();
          chk("word_data", dataOut, w.d);
          chk("word_nr", nr, w.nr);
          chk("word_last", last, w.last);
        end
      end
      if (inValid && inReady) begin
        for (int j = 0; j < 4; j++) begin
          w.d    = dataIn[127-32*j -: 32];
          w.nr   = word_idx_t'(j);
          w.last = (j == 3);
          q.push_back(w);
        end
      end
    end
  end

  initial begin
    logic [127:0] blk [3];
    int acc [3];
    int bi;
    int gaps;
    int n;

    // Reset with a block offered: nothing accepted.
    inValid  = 1'b1;
    dataIn   = K;
    outReady = 1'b1;
    repeat (2) begin
      look();
      chk("rst_inReady", inReady, 0);
      chk("rst_outValid", outValid, 0);
      chk("rst_dataOut", dataOut, 0);
      chk("rst_nr", nr, 0);
    end
    step();
    reset   = 1'b0;
    inValid = 1'b0;
    look();
    chk("rel_inReady", inReady, 1);
    step();
    look();
    chk("rel_no_block", outValid, 0);

    // Single block, word order and last flag.
    idle(2);
    inValid = 1'b1;
    dataIn  = K;
    step();
    inValid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      look();
      chk("one_valid", outValid, 1);
      chk("one_data", dataOut, K[127-32*j -: 32]);
      chk("one_nr", nr, j);
      chk("one_last", last, j == 3);
      step();
    end
    look();
    chk("one_done", outValid, 0);

    // Three blocks back to back.
    idle(4);
    for (int i = 0; i < 3; i++)
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
    bi      = 0;
    gaps    = 0;
    inValid = 1'b1;
    dataIn  = blk[0];
    for (int e = 0; e < 16; e++) begin
      look();
      if (inValid && inReady && bi < 3) begin
        acc[bi] = e;
        bi++;
      end
      if ((e >= 1 && e <= 12) != outValid) gaps++;
      step();
      if (bi < 3) dataIn = blk[bi];
      else inValid = 1'b0;
    end
    chk("burst_count", bi, 3);
    chk("burst_accA", acc[0], 0);
    chk("burst_accB", acc[1], 1);
    chk("burst_accC", acc[2], 5);
    chk("burst_gaps", gaps, 0);

    // Backpressure on word 1.
    idle(4);
    inValid = 1'b1;
    dataIn  = K;
    step();
    inValid = 1'b0;
    step();
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("bp_valid", outValid, 1);
      chk("bp_data", dataOut, 32'h44556677);
      chk("bp_nr", nr, 1);
      step();
    end
    outReady = 1'b1;
    idle(8);

    // New block accepted on the edge that consumes the last word.
    inValid = 1'b1;
    dataIn  = K;
    step();
    inValid = 1'b0;
    repeat (3) step();
    inValid = 1'b1;
    dataIn  = D;
    look();
    chk("sim_last", last, 1);
    chk("sim_inReady", inReady, 1);
    step();
    inValid = 1'b0;
    look();
    chk("sim_data", dataOut, 32'hDEADBEEF);
    chk("sim_nr", nr, 0);
    chk("sim_hold_empty", inReady, 1);
    idle(8);

    // Reset with hold full and nr = 2.
    inValid = 1'b1;
    dataIn  = K;
    step();
    dataIn = D;
    look();
    chk("mid_takeB", inReady, 1);
    step();
    inValid = 1'b0;
    step();
    reset = 1'b1;
    look();
    chk("mid_nr", nr, 2);
    chk("mid_full", inReady, 0);
    step();
    reset = 1'b0;
    look();
    chk("mid_valid", outValid, 0);
    chk("mid_data", dataOut, 0);
    chk("mid_nr0", nr, 0);
    inValid = 1'b1;
    dataIn  = K;
    step();
    inValid = 1'b0;
    look();
    chk("mid_new_data", dataOut, 32'h00112233);
    chk("mid_new_nr", nr, 0);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      inValid  = ($urandom_range(0, 9) < 6);
      dataIn   = {$urandom, $urandom, $urandom, $urandom};
      outReady = ($urandom_range(0, 9) < 7);
    end
    step();
    inValid  = 1'b0;
    outReady = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_empty", q.size(), 0);
    look();
    chk("drain_idle", outValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
